// File: rtl/spike_input_queue.sv
// spike_input_queue
//   Buffers single-cycle presynaptic spike pulses and presents them, oldest
//   first, to the network controller's spike input port. Absorbs bursts while
//   the controller is busy; when full, new spikes are dropped and counted.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   clear             synchronous flush of queued entries (drop_count and
//                     ack_err are kept)
//   spike_valid/index incoming spike pulse and its presynaptic index
//   spike_ready       queue can accept a spike this cycle
//   input_occurred    queue non-empty (to controller)
//   input_index       head entry (to controller)
//   input_ack         controller consumes the head entry
//   level             current occupancy
//   drop_count        saturating count of spikes lost to a full queue
//   ack_err           sticky: input_ack seen while the queue was empty
module spike_input_queue #(
    parameter int SR_DEPTH = 16384,
    parameter int Q_DEPTH  = 8,
    parameter int DROP_W   = 16,
    localparam int IW = $clog2(SR_DEPTH),
    localparam int LW = $clog2(Q_DEPTH + 1),
    localparam int PW = $clog2(Q_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              spike_valid,
    input  logic [IW-1:0]     spike_index,
    output logic              spike_ready,
    output logic              input_occurred,
    output logic [IW-1:0]     input_index,
    input  logic              input_ack,
    output logic [LW-1:0]     level,
    output logic [DROP_W-1:0] drop_count,
    output logic              ack_err
);

    logic [IW-1:0]     mem_q [Q_DEPTH];
    logic [IW-1:0]     mem_d [Q_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ack_err_q, ack_err_d;

    logic not_full;
    logic pop;
    logic push;

    // Pointer wrap handles non-power-of-two depths.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        next_ptr = (p == PW'(Q_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        sat_inc = (v == '1) ? v : v + DROP_W'(1);
    endfunction

    always_comb begin
        not_full = (count_q < LW'(Q_DEPTH));
        pop      = input_ack && (count_q != '0);
        // A full queue being popped this cycle frees the slot for the new spike.
        push     = spike_valid && (not_full || pop);

        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        drop_d    = drop_q;
        ack_err_d = ack_err_q || (input_ack && (count_q == '0));

        if (clear) begin
            // Flush wins over any push/pop; a coincident spike is not a drop.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = spike_index;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
            if (spike_valid && !push) begin
                drop_d = sat_inc(drop_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign spike_ready    = not_full || pop;
    assign input_occurred = (count_q != '0);
    assign input_index    = mem_q[rd_ptr_q];
    assign level          = count_q;
    assign drop_count     = drop_q;
    assign ack_err        = ack_err_q;

endmodule

// File: tb/tb_spike_input_queue.sv
module tb_spike_input_queue;

    localparam int IW = 14;
    localparam int LW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          spike_valid = 1'b0;
    logic [IW-1:0] spike_index = '0;
    logic          spike_ready;
    logic          input_occurred;
    logic [IW-1:0] input_index;
    logic          input_ack = 1'b0;
    logic [LW-1:0] level;
    logic [DW-1:0] drop_count;
    logic          ack_err;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    spike_input_queue #(.SR_DEPTH(16384), .Q_DEPTH(8), .DROP_W(4)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .spike_valid(spike_valid), .spike_index(spike_index),
        .spike_ready(spike_ready), .input_occurred(input_occurred),
        .input_index(input_index), .input_ack(input_ack),
        .level(level), .drop_count(drop_count), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every consumed head is compared with the oldest expected index.
    always @(negedge clk) begin
        if (!reset && input_ack && input_occurred) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_order: got %0d expected nothing queued", input_index);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(input_index) != e) begin
                    bad++;
                    $display("FAIL pop_order: got %0d expected %0d", input_index, e);
                end
            end
        end
    end

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic v, input int idx, input logic ack, input logic clr);
        spike_valid = v;
        spike_index = IW'(idx);
        input_ack   = ack;
        clear       = clr;
        @(posedge clk);
        #1;
        spike_valid = 1'b0;
        input_ack   = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic push_exp(input int idx);
        exp_q.push_back(idx);
        cyc(1'b1, idx, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) cyc(1'b0, 0, 1'b0, 1'b0);
        check("rst_occurred", input_occurred, 0);
        check("rst_level", level, 0);
        check("rst_ready", spike_ready, 1);
        check("rst_drop", drop_count, 0);
        check("rst_ack_err", ack_err, 0);

        // Single spike: visible after push edge, gone after ack edge
        push_exp(12'h0A5);
        check("single_occ_n1", input_occurred, 1);
        check("single_idx_n1", input_index, 12'h0A5);
        cyc(1'b0, 0, 1'b0, 1'b0);
        check("single_occ_n2", input_occurred, 1);
        check("single_idx_n2", input_index, 12'h0A5);
        cyc(1'b0, 0, 1'b1, 1'b0);
        check("single_occ_after", input_occurred, 0);
        check("single_level_after", level, 0);

        // Overflow: 10 spikes into 8 slots
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) push_exp(i);
            else cyc(1'b1, i, 1'b0, 1'b0);
            if (i == 8) begin
                check("ovf_level8", level, 8);
                check("ovf_ready0", spike_ready, 0);
            end
        end
        check("ovf_drop", drop_count, 2);
        check("ovf_level", level, 8);
        drain(8);
        check("ovf_drained", level, 0);

        // Full queue, push and pop together
        for (int i = 1; i <= 8; i++) push_exp(i);
        spike_valid = 1'b1;
        spike_index = IW'(99);
        input_ack   = 1'b1;
        exp_q.push_back(99);
        #1;
        check("full_pp_ready", spike_ready, 1);
        @(posedge clk);
        #1;
        spike_valid = 1'b0;
        input_ack   = 1'b0;
        check("full_pp_level", level, 8);
        check("full_pp_drop", drop_count, 2);
        check("full_pp_head", input_index, 2);
        drain(8);
        check("full_pp_drained", level, 0);

        // Error and flush
        cyc(1'b0, 0, 1'b1, 1'b0);
        check("err_flag", ack_err, 1);
        check("err_level", level, 0);
        for (int i = 0; i < 3; i++) push_exp(40 + i);
        check("flush_pre_level", level, 3);
        cyc(1'b1, 55, 1'b0, 1'b1);
        exp_q.delete();
        check("flush_level", level, 0);
        check("flush_occ", input_occurred, 0);
        check("flush_drop", drop_count, 2);
        check("flush_ack_err", ack_err, 1);

        // Wrap-around: 24 spikes, controller acks every cycle after the second
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(100 + i);
            cyc(1'b1, 100 + i, (i >= 2), 1'b0);
        end
        check("wrap_level", level, 2);
        drain(2);
        check("wrap_drained", level, 0);

        // Saturation: fill, then 20 more spikes against a full queue
        for (int i = 0; i < 8; i++) push_exp(200 + i);
        repeat (20) cyc(1'b1, 300, 1'b0, 1'b0);
        check("sat_drop", drop_count, 15);
        check("sat_level", level, 8);
        drain(8);

        // Asynchronous reset with 5 entries queued
        for (int i = 0; i < 5; i++) push_exp(500 + i);
        check("prereset_level", level, 5);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("areset_occ", input_occurred, 0);
        check("areset_idx", input_index, 0);
        check("areset_ready", spike_ready, 1);
        check("areset_level", level, 0);
        check("areset_drop", drop_count, 0);
        check("areset_ack_err", ack_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b0, 0, 1'b0, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_input_queue.md
# spike_input_queue

Buffers presynaptic spike events arriving as single-cycle pulses and presents them, oldest first, to `network_controller`'s spike input port (`input_occurred` / `input_index` / `input_ack`). It sits directly upstream of the controller. It absorbs bursts while the controller is busy in its neuron or accumulation sweeps. When the buffer is full it drops new spikes and counts them.

## Interface
- `SR_DEPTH`, 16384: number of presynaptic neurons; sets the index width `IW = $clog2(SR_DEPTH)`.
- `Q_DEPTH`, 8: queue capacity in entries, ≥ 2; does not need to be a power of two.
- `DROP_W`, 16: width of the drop counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clear`  in  1  synchronous flush; empties the queue, keeps `drop_count`.
- `spike_valid`  in  1  single-cycle spike pulse from the source; the source never holds or retries it.
- `spike_index`  in  IW  index of the spiking presynaptic neuron; qualified by `spike_valid`.
- `spike_ready`  out  1  the queue can accept a spike this cycle (informational to the source).
- `input_occurred`  out  1  to the controller; the queue is non-empty.
- `input_index`  out  IW  to the controller; index at the queue head.
- `input_ack`  in  1  from the controller; one-cycle pulse that consumes the head entry.
- `level`  out  $clog2(Q_DEPTH+1)  current occupancy.
- `drop_count`  out  DROP_W  number of spikes lost to a full queue; saturates.
- `ack_err`  out  1  sticky flag; set when `input_ack` arrives while the queue is empty.

## Operation
- **Storage:** register array `mem[Q_DEPTH]`, plus `rd_ptr`, `wr_ptr` and `count`.
  - Each pointer advances by 1 and wraps from `Q_DEPTH-1` to 0.
- **Outputs from state:**
  - `input_occurred = (count != 0)`.
  - `input_index = mem[rd_ptr]`, read combinationally from registered state.
  - `level = count`.
- **Pop:** `pop = input_ack && count != 0`. `rd_ptr` advances; the entry is discarded.
- **Push:** `push = spike_valid && (count < Q_DEPTH || pop)`. The spike is written at `wr_ptr`, then `wr_ptr` advances.
- **Ready:** `spike_ready = (count < Q_DEPTH) || pop`. This is combinational from `input_ack`. A full queue popped in the same cycle accepts the incoming spike.
- **Drop:** `spike_valid && !push` increments `drop_count`, saturating at all-ones. The dropped spike is not stored.
- **Count update:** `count` becomes `count + push - pop`. Push and pop in the same cycle leave `count` unchanged.
- **Ack on empty:** `input_ack` while `count == 0` is ignored and sets `ack_err`. The flag stays set until `reset`.
- **Clear:** `clear` sets `rd_ptr`, `wr_ptr` and `count` to 0 and discards any push or pop in the same cycle. A `spike_valid` in the same cycle is neither stored nor counted as a drop. `drop_count` and `ack_err` are kept.
- **Ordering:** strict FIFO. Duplicate indices are stored as separate entries; there is no coalescing.
- **Reset:**
  - State: `rd_ptr = wr_ptr = count = 0`.
  - Outputs: `input_occurred = 0`, `input_index = 0` (`mem` cleared), `spike_ready = 1`, `level = 0`, `drop_count = 0`, `ack_err = 0`.
  - Reset asserted mid-operation discards all queued spikes immediately (asynchronously).

## Timing
- **Push to visible:** a spike pushed at edge N into an empty queue makes `input_occurred = 1` and `input_index` valid after edge N, so the controller can sample it at edge N+1.
- **Head stability:** `input_index` is stable while `input_occurred` is high until the edge at which `input_ack` is sampled high.
- **Ack timing:** the controller registers `input_ack`, so it is high during the cycle after the controller samples the head. The pop takes effect at the end of that cycle. The new head is visible in the following cycle.
- **Stale head:** between the controller's sample and the pop, the old head is still shown. The controller only samples on alternate cycles (phase 1), so it does not re-sample during this window; the queue needs no extra guard.
- **Throughput:** one push and one pop per cycle; no bubbles.
- **Drop latency:** `drop_count` updates at the edge that refuses the spike.

## Test plan
- **Reset values:** assert `reset`, release, idle 3 cycles → `input_occurred = 0`, `level = 0`, `spike_ready = 1`, `drop_count = 0`, `ack_err = 0`.
- **Single spike:** push index 0x0A5 at edge N; pulse `input_ack` in cycle N+2 →
  - `input_occurred = 1` and `input_index = 0x0A5` from N+1 through N+2;
  - `input_occurred = 0` and `level = 0` after edge N+2.
- **Overflow:** with `Q_DEPTH = 8`, push indices 1..10 on consecutive cycles with no ack →
  - `level = 8`, `spike_ready = 0` after the 8th push;
  - `drop_count = 2`;
  - acking 8 times returns 1..8 in order.
- **Full queue, push and pop together:** queue full with 1..8; `spike_valid` (index 99) and `input_ack` in the same cycle →
  - `level` stays 8, `drop_count` unchanged, head becomes 2;
  - draining returns 2..8 then 99.
- **Wrap-around and saturation:** run 3 × `Q_DEPTH` spikes with interleaved acks against a controller model →
  - output order matches input order across the pointer wrap;
  - with `DROP_W = 4`, drive 20 spikes into a full queue → `drop_count` saturates at 15.
- **Error and flush:**
  - `input_ack` while empty → `ack_err = 1`, `level` stays 0.
  - Then push 3 spikes, assert `clear` together with `spike_valid` → `level = 0`, `input_occurred = 0` next cycle, `drop_count` unchanged, `ack_err` still 1.
  - Assert `reset` with 5 entries queued → all outputs at reset values immediately.
